// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified IF/MEM memory port: one transaction at a time, data first, fetch starvation guard.
// Optional mem_ack watchdog and sticky err flag are enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_param_check
        $error("mem_port_arbiter: STARVE_MAX or TIMEOUT out of range");
    end

    state_t     state_r;
    logic       grant_r;
    logic [3:0] starve_cnt_r;
    logic       pick_dm_s;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Winner selection: data wins a tie unless fetch has waited STARVE_MAX data grants.
    always_comb begin
        pick_dm_s = 1'b0;
        if (dm_req && (!if_req || (starve_cnt_r != STARVE_LIM))) begin
            pick_dm_s = 1'b1;
        end else begin
            pick_dm_s = 1'b0;
        end
    end

    // Stall requests to the hazard unit while a request is not yet completing.
    always_comb begin
        stall_f = if_req & ~if_ready;
        stall_m = dm_req & ~dm_ready;
    end

    // Transaction sequencer: grant in IDLE, wait for ack in BUSY, pulse ready in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            starve_cnt_r <= 4'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'd0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ready     <= 1'b0;
            dm_ready     <= 1'b0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_r    <= '0;
            err_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (if_req || dm_req) begin
                        grant_r <= pick_dm_s;
                        mem_req <= 1'b1;
                        state_r <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt_r <= '0;
`endif
                        if (pick_dm_s) begin
                            mem_we    <= dm_we;
                            mem_be    <= dm_be;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (!if_req) begin
                                starve_cnt_r <= 4'd0;
                            end else if (starve_cnt_r != STARVE_LIM) begin
                                starve_cnt_r <= starve_cnt_r + 4'd1;
                            end
                        end else begin
                            mem_we       <= 1'b0;
                            mem_be       <= 4'hF;
                            mem_addr     <= if_addr;
                            mem_wdata    <= '0;
                            starve_cnt_r <= 4'd0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= DONE;
                        if (grant_r) begin
                            dm_ready <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        mem_req <= 1'b0;
                        err_r   <= 1'b1;
                        state_r <= DONE;
                        if (grant_r) begin
                            dm_ready <= 1'b1;
                            dm_rdata <= '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // The completed requester's request is still high here, so nothing is sampled.
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory port of the pipelined RISC-V CPU between the fetch stage (IF) and the memory stage (MEM). It arbitrates level-held requests, sequences one memory transaction at a time through a small FSM, and returns a one-cycle ready pulse. Its stall outputs feed the hazard unit alongside the controller's decode outputs. Data accesses have priority, and a starvation guard protects fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (1..15)
- TIMEOUT, 16, mem_ack watchdog limit in cycles; used only with ARB_TIMEOUT_EN
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid with if_ready
- if_ready  out  1  one-cycle completion pulse to fetch
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  data write enable
- dm_be  in  4  byte enables (writes)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid with dm_ready
- dm_ready  out  1  one-cycle completion pulse to MEM
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/ADDR_W/DATA_W  registered transaction fields
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, may arrive in the first mem_req cycle
- stall_f  out  1  if_req & ~if_ready
- stall_m  out  1  dm_req & ~dm_ready
- err  out  1  sticky timeout flag

## Operation
- FSM states are IDLE, BUSY, and DONE. Reset puts the FSM in IDLE.
- Reset values: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, err=0, starve_cnt=0, and the grant register (0=IF, 1=DM) is 0.
- IDLE with no request: the FSM stays in IDLE.
- IDLE with any request: the arbiter picks a winner, registers its fields into mem_*, records the grant, and moves to BUSY.
  - Fetch transactions force mem_we=0 and mem_be=4'hF.
- Arbitration:
  - When only one requester is active, it wins.
  - When both are active, DM wins, unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt behaviour:
  - It increments on a DM grant while if_req is high, saturating at STARVE_MAX.
  - It clears on any IF grant.
  - It clears on a DM grant when if_req is low.
- BUSY: mem_req=1 and all mem_* fields are held stable. On mem_ack, the arbiter captures mem_rdata into the granted port's rdata register and moves to DONE.
- DONE: the arbiter pulses the granted port's ready for exactly one cycle. It does not sample requests. It moves to IDLE next.
  - The requester's request is still high in DONE, and DONE exists so that this stale request is never re-granted.
- The rdata registers hold their value until the next completion on the same port.
- Writes return rdata unchanged: the arbiter does not capture mem_rdata for writes.
- stall_f and stall_m are combinational from the inputs and the ready registers.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and mem_req drops asynchronously.
  - No ready pulse is produced.
  - A late mem_ack arriving in IDLE is ignored.

## Timing
- Minimum latency from request to ready is 3 cycles, with ack in the first BUSY cycle:
  - cycle 0: IDLE grants.
  - cycle 1: BUSY with mem_ack.
  - cycle 2: DONE with ready=1.
  - cycle 3: IDLE, new request sampled.
- Each extra wait cycle on mem_ack adds one cycle.
- Back-to-back throughput is one transaction per 3 cycles.
- if_ready and dm_ready are never high in the same cycle.
- Requests that deassert before ready are a protocol violation. Their behaviour is undefined, and the bench checks the assertion.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY.
  - If mem_ack has not arrived after TIMEOUT cycles, the FSM moves to DONE, the granted rdata loads 0, the ready pulse is produced, err sets, and mem_req drops.
  - err stays set until reset.
- ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely and err is tied to 0.

## Test plan
- Single fetch: if_req=1, if_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, if_ready pulses at cycle 2, if_rdata=0x00500093, and there is no second grant in DONE.
- Simultaneous requests: if_req=dm_req=1 with dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_be=4'hF -> DM is granted first with mem_we=1; IF is granted next.
- Starvation: dm_req held high with continuous re-requests and if_req high, STARVE_MAX=4 -> 4 DM grants, then the 5th grant goes to IF, and starve_cnt returns to 0.
- Wait states: mem_ack delayed 5 cycles -> mem_* are stable across all BUSY cycles, stall_m stays high, and dm_ready pulses 7 cycles after the grant.
- Reset mid-BUSY: assert reset in cycle 1 -> mem_req=0 in the same cycle, no ready pulse, and a subsequent stray mem_ack is ignored.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): no mem_ack -> after 16 BUSY cycles dm_ready pulses, dm_rdata=0, and err=1 is sticky until reset.
